// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// UartTransmitter
//
// Serial UART transmitter with a one-word holding register in front of the
// shift FSM. While one frame is shifting out, the next word can already be
// queued. Frame: one start bit (0), DBIT data bits LSB first, and a stop
// level (1) lasting SB_TICK oversampling ticks. There is no parity bit.
//
// Ports
//   clock         system clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   s_tick        baud oversampling strobe, one clock wide, 16 per bit
//   tx_start      request to queue din (refused while hold_full is high)
//   din           data word captured when tx_start is accepted
//   tx            registered serial line, idles high
//   tx_done_tick  one-clock pulse when a frame's stop bit completes
//   hold_full     the holding register contains a word not yet transferred
//   busy          the FSM is in START, DATA or STOP
// ---------------------------------------------------------------------------
module uart_transmitter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            hold_full,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int            NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);
  localparam logic [4:0]    BIT_LAST  = 5'd15;
  localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);

  state_t          state_q;
  logic [4:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shift_q;
  logic [DBIT-1:0] shift_d;
  logic [DBIT-1:0] hold_q;
  logic            hold_full_q;
  logic            tx_q;
  logic            done_q;

  // Shifter contents after the current bit is retired; its LSB is the level
  // the line must take for the following data bit.
  assign shift_d = shift_q >> 1;

  // Holding register and transmit FSM. tx is registered, so every transition
  // also loads the line level belonging to the state being entered; this is
  // what makes the start bit appear one clock after IDLE sees a held word.
  // A request is judged against the registered hold_full, so a request made
  // in the very cycle IDLE empties the holding register is still refused.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (tx_start && !hold_full_q) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            s_q         <= '0;
            n_q         <= '0;
            tx_q        <= 1'b0;
            state_q     <= START;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_q == BIT_LAST) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= shift_q[0];
              state_q <= DATA;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_q == BIT_LAST) begin
              s_q     <= '0;
              shift_q <= shift_d;
              n_q     <= n_q + 1'b1;
              if (n_q == LAST_BIT) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                tx_q <= shift_d[0];
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_q == STOP_LAST) begin
              s_q     <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign hold_full    = hold_full_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// TbUartTransmitter
//
// Directed bench for uart_transmitter. Two instances share the stimulus: one
// with the default 16-tick stop bit and one with SB_TICK = 32. A line monitor
// per instance decodes frames by counting s_tick strobes, records each
// frame's byte, stop length, length in clocks, idle gap before it and
// whether the line moved within a bit.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

  logic       clock;
  logic       reset;
  logic       sTick;
  logic       txStart;
  logic [7:0] din;
  logic       txLine, doneTick, holdFull, busy;
  logic       tx32, done32, hold32, busy32;

  int assertCount = 0;
  int failCount   = 0;
  int tickDiv     = 1;
  int cyc         = 0;
  int doneCount[2];
  bit monTimeout  = 0;

  int         frameCount[2];
  logic [7:0] rxByte[2][32];
  int         rxStop[2][32];
  int         rxGap[2][32];
  int         rxLen[2][32];
  bit         rxGlitch[2][32];
  logic       rxHold[2][32];
  int         lastDone[2];

  uart_transmitter dut (
    .clock(clock), .reset(reset), .s_tick(sTick), .tx_start(txStart), .din(din),
    .tx(txLine), .tx_done_tick(doneTick), .hold_full(holdFull), .busy(busy)
  );

  uart_transmitter #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clock(clock), .reset(reset), .s_tick(sTick), .tx_start(txStart), .din(din),
    .tx(tx32), .tx_done_tick(done32), .hold_full(hold32), .busy(busy32)
  );

  // Free-running clock and cycle counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Baud strobe: one clock high every tickDiv clocks, changed shortly after
  // the rising edge so it is stable for the next one.
  initial begin
    int cnt;
    cnt   = 0;
    sTick = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (cnt >= tickDiv - 1) begin
        cnt   = 0;
        sTick = 1'b1;
      end else begin
        cnt++;
        sTick = 1'b0;
      end
    end
  end

  // Done pulses are counted per clock, so a stretched pulse shows up as extra.
  initial begin
    doneCount[0] = 0;
    doneCount[1] = 0;
    frameCount[0] = 0;
    frameCount[1] = 0;
    lastDone[0] = 0;
    lastDone[1] = 0;
  end
  always @(negedge clock) begin
    if (doneTick === 1'b1) doneCount[0] <= doneCount[0] + 1;
    if (done32 === 1'b1) doneCount[1] <= doneCount[1] + 1;
  end

  function automatic logic lineOf(input int s);
    return (s != 0) ? tx32 : txLine;
  endfunction

  function automatic logic doneOf(input int s);
    return (s != 0) ? done32 : doneTick;
  endfunction

  function automatic logic holdOf(input int s);
    return (s != 0) ? hold32 : holdFull;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Frame decoder for one instance. Each bit lasts 16 consumed strobes; the
  // stop level is measured in strobes up to the done pulse. Reset aborts.
  task automatic monitorLine(input int s);
    int         ticks, guard, stopTicks, startCyc, idx;
    logic       level;
    logic [7:0] data;
    bit         glitch, aborted;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && lineOf(s) === 1'b0) begin
        startCyc = cyc;
        glitch   = 0;
        aborted  = 0;
        data     = '0;
        for (int seg = 0; seg <= 8 && !aborted; seg++) begin
          level = lineOf(s);
          ticks = 0;
          while (ticks < 16 && !aborted) begin
            if (reset === 1'b1) begin
              aborted = 1;
            end else begin
              if (lineOf(s) !== level) glitch = 1;
              if (sTick) ticks++;
              @(negedge clock);
            end
          end
          if (!aborted) begin
            if (seg == 0) begin
              if (level !== 1'b0) glitch = 1;
            end else begin
              data[seg-1] = level;
            end
          end
        end
        stopTicks = 0;
        guard     = 0;
        while (!aborted && doneOf(s) !== 1'b1) begin
          if (reset === 1'b1) begin
            aborted = 1;
          end else if (guard > 4000) begin
            aborted    = 1;
            monTimeout = 1;
          end else begin
            if (lineOf(s) !== 1'b1) glitch = 1;
            if (sTick) stopTicks++;
            guard++;
            @(negedge clock);
          end
        end
        if (!aborted && frameCount[s] < 32) begin
          idx = frameCount[s];
          rxByte[s][idx]   = data;
          rxStop[s][idx]   = stopTicks;
          rxGap[s][idx]    = startCyc - lastDone[s];
          rxLen[s][idx]    = cyc - startCyc;
          rxGlitch[s][idx] = glitch;
          rxHold[s][idx]   = holdOf(s);
          lastDone[s]      = cyc;
          frameCount[s]    = idx + 1;
        end
      end
    end
  endtask

  initial monitorLine(0);
  initial monitorLine(1);

  // One-cycle tx_start pulse; the word is accepted at the second rising edge.
  task automatic applyStimulus(input logic [7:0] value);
    @(posedge clock);
    #1;
    txStart = 1'b1;
    din     = value;
    @(posedge clock);
    #1;
    txStart = 1'b0;
  endtask

  task automatic waitFrames(input int s, input int n, input string tag);
    int g;
    g = 0;
    while (frameCount[s] < n && g < 20000) begin
      @(negedge clock);
      g++;
    end
    checkOutput(tag, frameCount[s], n);
  endtask

  task automatic waitIdle(input string tag);
    int g;
    g = 0;
    @(negedge clock);
    while ((busy !== 1'b0 || holdFull !== 1'b0 || busy32 !== 1'b0 || hold32 !== 1'b0) && g < 20000) begin
      @(negedge clock);
      g++;
    end
    checkOutput(tag, {busy, holdFull, busy32, hold32}, 4'b0000);
  endtask

  initial begin
    int base, baseD, base1;

    reset   = 1'b1;
    txStart = 1'b0;
    din     = 8'h00;

    // Reset state, with a request presented during reset.
    repeat (3) @(posedge clock);
    #1 txStart = 1'b1; din = 8'hE1;
    @(negedge clock);
    checkOutput("resetOutputs", {txLine, busy, holdFull, doneTick}, 4'b1000);
    @(posedge clock);
    #1 txStart = 1'b0; reset = 1'b0;

    // Fifty idle clocks with no request.
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      checkOutput("idleOutputs", {txLine, busy, holdFull, doneTick}, 4'b1000);
    end

    // Latency, refusal in the emptying cycle, and refill while shifting.
    tickDiv = 1000;
    @(posedge clock);
    #1 txStart = 1'b1; din = 8'hC3;
    @(posedge clock);
    #1 din = 8'h77;
    @(negedge clock);
    checkOutput("latencyHold", {txLine, busy, holdFull}, 3'b101);
    @(posedge clock);
    #1 din = 8'h3C;
    @(negedge clock);
    checkOutput("latencyStart", {txLine, busy, holdFull}, 3'b010);
    @(posedge clock);
    #1 txStart = 1'b0;
    @(negedge clock);
    checkOutput("refillDuringFrame", holdFull, 1'b1);
    tickDiv = 1;
    base = frameCount[0];
    waitFrames(0, base + 2, "refillFrames");
    checkOutput("refillByte0", rxByte[0][base], 8'hC3);
    checkOutput("refillByte1", rxByte[0][base+1], 8'h3C);
    checkOutput("refillGap", rxGap[0][base+1], 1);
    checkOutput("refillGlitch", {rxGlitch[0][base], rxGlitch[0][base+1]}, 2'b00);
    waitIdle("idleAfterRefill");

    // Single frame 0xA5 with a strobe every clock.
    tickDiv = 1;
    base  = frameCount[0];
    baseD = doneCount[0];
    applyStimulus(8'hA5);
    waitFrames(0, base + 1, "a5Frame");
    checkOutput("a5Byte", rxByte[0][base], 8'hA5);
    checkOutput("a5Length", rxLen[0][base], 160);
    checkOutput("a5Stop", rxStop[0][base], 16);
    checkOutput("a5Glitch", rxGlitch[0][base], 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("a5DonePulses", doneCount[0] - baseD, 1);
    waitIdle("idleAfterA5");

    // Queued second word at a slower strobe; a third request is refused.
    tickDiv = 4;
    base  = frameCount[0];
    baseD = doneCount[0];
    applyStimulus(8'h55);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("firstLoaded", {busy, holdFull}, 2'b10);
    applyStimulus(8'h0F);
    @(negedge clock);
    checkOutput("secondQueued", holdFull, 1'b1);
    applyStimulus(8'hFF);
    @(negedge clock);
    checkOutput("thirdRefused", holdFull, 1'b1);
    waitFrames(0, base + 2, "queuedFrames");
    checkOutput("queuedByte0", rxByte[0][base], 8'h55);
    checkOutput("queuedByte1", rxByte[0][base+1], 8'h0F);
    checkOutput("queuedHoldAtDone", {rxHold[0][base], rxHold[0][base+1]}, 2'b10);
    checkOutput("queuedGap", rxGap[0][base+1], 1);
    checkOutput("queuedGlitch", {rxGlitch[0][base], rxGlitch[0][base+1]}, 2'b00);
    repeat (300) @(negedge clock);
    checkOutput("noThirdFrame", frameCount[0], base + 2);
    checkOutput("queuedDonePulses", doneCount[0] - baseD, 2);
    waitIdle("idleAfterQueued");

    // Reset during data bit 3 with a second word held.
    tickDiv = 1;
    base  = frameCount[0];
    baseD = doneCount[0];
    applyStimulus(8'h96);
    applyStimulus(8'h42);
    repeat (67) @(posedge clock);
    @(negedge clock);
    checkOutput("midFrameState", {busy, holdFull}, 2'b11);
    @(posedge clock);
    #1 reset = 1'b1; txStart = 1'b1; din = 8'hE7;
    @(posedge clock);
    #1 reset = 1'b0; txStart = 1'b0;
    @(negedge clock);
    checkOutput("abortOutputs", {txLine, busy, holdFull, doneTick}, 4'b1000);
    repeat (400) @(negedge clock);
    checkOutput("abortNoFrame", frameCount[0], base);
    checkOutput("abortNoDone", doneCount[0] - baseD, 0);
    checkOutput("abortQuiet", {txLine, busy, holdFull}, 3'b100);

    // Two stop bits on the SB_TICK = 32 instance.
    tickDiv = 1;
    base1 = frameCount[1];
    applyStimulus(8'h00);
    waitFrames(1, base1 + 1, "longStopFrame");
    checkOutput("longStopByte", rxByte[1][base1], 8'h00);
    checkOutput("longStopTicks", rxStop[1][base1], 32);
    checkOutput("longStopLength", rxLen[1][base1], 176);
    checkOutput("longStopGlitch", rxGlitch[1][base1], 1'b0);
    waitIdle("idleAfterLongStop");

    checkOutput("monitorTimeout", monTimeout, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
